mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM/IO port between instruction fetch (word reads that feed the
//  instruction queue) and the load/store buffer (1/2/4-byte reads and writes). Serialises each
//  request into byte accesses and assembles or splits little-endian words. Arbitrates
//  round-robin between the two requesters. Aborts speculative reads on a reorder-buffer flush.
// PARAMETERS
//  AddrWidth  32        width of all address ports
//  IOBase     32'h30000 addresses >= IOBase are IO; writes to them honour io_buffer_full_in
// PORTS
//  clk_in              in   1   clock
//  rst_in              in   1   synchronous active-high reset
//  rdy_in              in   1   low = chip paused: every register holds
//  mem_din             in   8   RAM/IO read byte
//  mem_dout            out  8   RAM/IO write byte
//  mem_a               out  32  RAM/IO byte address
//  mem_wr              out  1   1 = write, 0 = read
//  io_buffer_full_in   in   1   IO output buffer full
//  if_mem_en_in        in   1   IF word-read request (level, held until done)
//  if_mem_addr_in      in   32  IF fetch address
//  mem_if_done_out     out  1   1-cycle pulse: mem_if_data_out valid
//  mem_if_data_out     out  32  fetched instruction word
//  lsb_mem_en_in       in   1   LSB request (level, held until done)
//  lsb_mem_wr_in       in   1   1 = store, 0 = load
//  lsb_mem_size_in     in   3   bytes: 1, 2 or 4 (other values: unsupported)
//  lsb_mem_addr_in     in   32  LSB address
//  lsb_mem_data_in     in   32  store data, low size bytes used
//  mem_lsb_done_out    out  1   1-cycle pulse: load data valid / store complete
//  mem_lsb_data_out    out  32  load data, zero-extended (sign extension is the LSB's job)
//  rob_mem_rst_in      in   1   misprediction flush
// BEHAVIOUR
//  Reset: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, both done=0, both data_out=0, cnt=0,
//   last_grant=IF (so LSB wins the first contention).
//  States: IDLE, READ, WRITE. Size N, counter cnt (3 bits), latched addr/data/owner.
//  IDLE accept edge (edge 0): no accept while either done output is high or rob_mem_rst_in=1.
//   Both requesting -> grant the one not in last_grant; else grant the sole requester.
//   Latch addr/N/data/owner, update last_grant, drive mem_a=addr, set cnt=1.
//   Read -> mem_wr=0, enter READ. Write -> mem_wr=1, mem_dout=data[7:0], enter WRITE.
//  Read timing: the byte at the address driven after edge t appears on mem_din in cycle t+1 and
//   is captured at edge t+2. Edges 1..N-1 drive mem_a=addr+k. Edges 2..N+1 capture byte k
//   into data[8k+7:8k]. At edge N+1: done pulse to owner, data_out updated, state IDLE.
//   The pulse is high in cycle N+2; a 4-byte read's result is visible 6 cycles after accept.
//  Write timing: edges 1..N-1 drive mem_a=addr+k, mem_dout=byte k, mem_wr=1. At edge N:
//   mem_wr=0, LSB done pulse, state IDLE.
//  IO stall: in WRITE with addr>=IOBase and io_buffer_full_in=1, the edge that would issue
//   the next byte instead sets mem_wr=0 and holds cnt. Issue resumes when full drops.
//  The next accept is possible at the edge after the done pulse.
//  Flush (rob_mem_rst_in=1): an IF read or LSB load in progress aborts at that edge.
//   State IDLE, mem_wr=0, no done pulse (also suppressed if due that edge). A store in
//   progress completes normally. Requests presented that edge are ignored.
//  Address arithmetic wraps modulo 2^AddrWidth; no alignment check.
//  rdy_in=0 has priority below rst_in and above everything else: full hold, no pulses.
//  done outputs are never both high; the data_out of each requester holds between pulses.
// TESTING
//  IF read 0x1000, RAM bytes 13,00,00,00 -> mem_a 0x1000..0x1003 on edges 0-3;
//   mem_if_done_out high cycle 6, data 0x00000013.
//  LSB store size 2, addr 0x20, data 0xABCD -> writes CD@0x20, AB@0x21 with mem_wr=1;
//   done at edge 2; no IF grant meanwhile.
//  Both requesting from reset -> LSB served first, then IF; with both held, grants alternate.
//  IF read flushed after edge 2 -> no mem_if_done_out; IDLE; a new request at the next edge is
//   accepted. The same flush during a store -> the store completes with done.
//  Store 1 byte to 0x30000 with io_buffer_full_in=1 for 3 cycles -> mem_wr=0 during stall,
//   byte written after full drops. rdy_in=0 mid-read -> all outputs frozen, result unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between instruction fetch and the load/store buffer.
// Requests are split into little-endian byte accesses; ownership alternates round-robin on contention.
module mem_arbiter #(
   parameter int unsigned          AddrWidth = 32,
   parameter logic [AddrWidth-1:0] IOBase    = AddrWidth'('h30000)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [AddrWidth-1:0] mem_a,
   output logic                 mem_wr,
   input  logic                 io_buffer_full_in,
   input  logic                 if_mem_en_in,
   input  logic [AddrWidth-1:0] if_mem_addr_in,
   output logic                 mem_if_done_out,
   output logic [31:0]          mem_if_data_out,
   input  logic                 lsb_mem_en_in,
   input  logic                 lsb_mem_wr_in,
   input  logic [2:0]           lsb_mem_size_in,
   input  logic [AddrWidth-1:0] lsb_mem_addr_in,
   input  logic [31:0]          lsb_mem_data_in,
   output logic                 mem_lsb_done_out,
   output logic [31:0]          mem_lsb_data_out,
   input  logic                 rob_mem_rst_in
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   typedef enum logic {OWN_IF, OWN_LSB} owner_t;

   state_t               state, nxt_state;
   owner_t               owner, nxt_owner;
   owner_t               last_grant, nxt_last_grant;
   logic [2:0]           cnt, nxt_cnt;
   logic [2:0]           size, nxt_size;
   logic [AddrWidth-1:0] addr, nxt_addr;
   logic [31:0]          data, nxt_data;
   logic [AddrWidth-1:0] nxt_mem_a;
   logic [7:0]           nxt_mem_dout;
   logic                 nxt_mem_wr;
   logic                 nxt_if_done, nxt_lsb_done;
   logic [31:0]          nxt_if_data, nxt_lsb_data;

   logic                 grant_lsb;
   logic                 idle_accept;
   logic [1:0]           rd_idx;
   logic [31:0]          rd_data;
   logic [7:0]           wr_byte;
   logic                 io_stall;

   function automatic logic [2:0] eff_size(input logic [2:0] s);
      case (s)
         3'd1:    eff_size = 3'd1;
         3'd2:    eff_size = 3'd2;
         default: eff_size = 3'd4;
      endcase
   endfunction

   always_comb begin
      grant_lsb   = lsb_mem_en_in && (!if_mem_en_in || last_grant == OWN_IF);
      idle_accept = !mem_if_done_out && !mem_lsb_done_out && !rob_mem_rst_in
                    && (if_mem_en_in || lsb_mem_en_in);
      // Read captures lag issue by two edges, so edge cnt lands byte cnt-2.
      rd_idx      = cnt[1:0] - 2'd2;
      rd_data     = data;
      rd_data[{rd_idx, 3'b000} +: 8] = mem_din;
      wr_byte     = data[{cnt[1:0], 3'b000} +: 8];
      io_stall    = (addr >= IOBase) && io_buffer_full_in;
   end

   always_comb begin
      nxt_state      = state;
      nxt_owner      = owner;
      nxt_last_grant = last_grant;
      nxt_cnt        = cnt;
      nxt_size       = size;
      nxt_addr       = addr;
      nxt_data       = data;
      nxt_mem_a      = mem_a;
      nxt_mem_dout   = mem_dout;
      nxt_mem_wr     = mem_wr;
      nxt_if_done    = 1'b0;
      nxt_lsb_done   = 1'b0;
      nxt_if_data    = mem_if_data_out;
      nxt_lsb_data   = mem_lsb_data_out;

      case (state)
         IDLE: begin
            if (idle_accept) begin
               nxt_owner      = grant_lsb ? OWN_LSB : OWN_IF;
               nxt_last_grant = grant_lsb ? OWN_LSB : OWN_IF;
               nxt_addr       = grant_lsb ? lsb_mem_addr_in : if_mem_addr_in;
               nxt_mem_a      = grant_lsb ? lsb_mem_addr_in : if_mem_addr_in;
               nxt_size       = grant_lsb ? eff_size(lsb_mem_size_in) : 3'd4;
               nxt_cnt        = 3'd1;
               if (grant_lsb && lsb_mem_wr_in) begin
                  nxt_data  = lsb_mem_data_in;
                  nxt_state = WRITE;
                  // A full IO buffer defers even the first byte; cnt=0 marks it unissued.
                  if (lsb_mem_addr_in >= IOBase && io_buffer_full_in) begin
                     nxt_cnt    = '0;
                     nxt_mem_wr = 1'b0;
                  end else begin
                     nxt_mem_wr   = 1'b1;
                     nxt_mem_dout = lsb_mem_data_in[7:0];
                  end
               end else begin
                  nxt_data   = '0;
                  nxt_mem_wr = 1'b0;
                  nxt_state  = READ;
               end
            end
         end

         READ: begin
            if (rob_mem_rst_in) begin
               nxt_state  = IDLE;
               nxt_mem_wr = 1'b0;
               nxt_cnt    = '0;
            end else begin
               if (cnt < size)
                  nxt_mem_a = addr + AddrWidth'(cnt);
               if (cnt >= 3'd2)
                  nxt_data = rd_data;
               if (cnt == size + 3'd1) begin
                  nxt_state = IDLE;
                  nxt_cnt   = '0;
                  if (owner == OWN_IF) begin
                     nxt_if_done = 1'b1;
                     nxt_if_data = rd_data;
                  end else begin
                     nxt_lsb_done = 1'b1;
                     nxt_lsb_data = rd_data;
                  end
               end else begin
                  nxt_cnt = cnt + 3'd1;
               end
            end
         end

         WRITE: begin
            if (cnt < size) begin
               if (io_stall) begin
                  nxt_mem_wr = 1'b0;
               end else begin
                  nxt_mem_a    = addr + AddrWidth'(cnt);
                  nxt_mem_dout = wr_byte;
                  nxt_mem_wr   = 1'b1;
                  nxt_cnt      = cnt + 3'd1;
               end
            end else begin
               nxt_mem_wr   = 1'b0;
               nxt_lsb_done = 1'b1;
               nxt_state    = IDLE;
               nxt_cnt      = '0;
            end
         end

         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= IDLE;
         owner            <= OWN_IF;
         last_grant       <= OWN_IF;
         cnt              <= '0;
         size             <= '0;
         addr             <= '0;
         data             <= '0;
         mem_a            <= '0;
         mem_dout         <= '0;
         mem_wr           <= 1'b0;
         mem_if_done_out  <= 1'b0;
         mem_lsb_done_out <= 1'b0;
         mem_if_data_out  <= '0;
         mem_lsb_data_out <= '0;
      end else if (rdy_in) begin
         state            <= nxt_state;
         owner            <= nxt_owner;
         last_grant       <= nxt_last_grant;
         cnt              <= nxt_cnt;
         size             <= nxt_size;
         addr             <= nxt_addr;
         data             <= nxt_data;
         mem_a            <= nxt_mem_a;
         mem_dout         <= nxt_mem_dout;
         mem_wr           <= nxt_mem_wr;
         mem_if_done_out  <= nxt_if_done;
         mem_lsb_done_out <= nxt_lsb_done;
         mem_if_data_out  <= nxt_if_data;
         mem_lsb_data_out <= nxt_lsb_data;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: synchronous byte RAM model, IO write log,
// and a queue of expected completions popped as done pulses arrive.
module tb_mem_arbiter;

   localparam logic [31:0] IO_BASE = 32'h30000;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_full;
   logic        if_en;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        lsb_en, lsb_wr;
   logic [2:0]  lsb_size;
   logic [31:0] lsb_addr, lsb_wdata;
   logic        lsb_done;
   logic [31:0] lsb_rdata;
   logic        flush;

   typedef struct {
      logic        lsb;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  io_q[$];
   logic [7:0]  ram [0:65535];
   int          n_cmp = 0;
   int          n_err = 0;

   mem_arbiter #(.AddrWidth(32), .IOBase(IO_BASE)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full_in(io_full),
      .if_mem_en_in(if_en), .if_mem_addr_in(if_addr),
      .mem_if_done_out(if_done), .mem_if_data_out(if_data),
      .lsb_mem_en_in(lsb_en), .lsb_mem_wr_in(lsb_wr), .lsb_mem_size_in(lsb_size),
      .lsb_mem_addr_in(lsb_addr), .lsb_mem_data_in(lsb_wdata),
      .mem_lsb_done_out(lsb_done), .mem_lsb_data_out(lsb_rdata),
      .rob_mem_rst_in(flush)
   );

   always #5 clk = ~clk;

   // Synchronous RAM that pauses with the rest of the chip.
   always @(posedge clk) begin
      if (rdy) begin
         if (mem_wr) begin
            if (mem_a >= IO_BASE) io_q.push_back(mem_dout);
            else                  ram[mem_a[15:0]] <= mem_dout;
         end
         mem_din <= ram[mem_a[15:0]];
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      if_en  = 1'b0;
      lsb_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Returns the index of the first negedge (0 = after the next posedge) showing a done pulse.
   task automatic wait_done(input int limit, output int cyc, output logic gi, output logic gl);
      cyc = -1; gi = 1'b0; gl = 1'b0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (if_done || lsb_done) begin
            cyc = c; gi = if_done; gl = lsb_done;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; io_full = 1'b0; flush = 1'b0;
      if_en = 1'b0; if_addr = '0;
      lsb_en = 1'b0; lsb_wr = 1'b0; lsb_size = 3'd1; lsb_addr = '0; lsb_wdata = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin
         n_err++;
         $display("FAIL reset_port: mem_a=%h mem_dout=%h mem_wr=%b, want 0/0/0", mem_a, mem_dout, mem_wr);
      end
      n_cmp++;
      if (if_done !== 1'b0 || lsb_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: if=%b lsb=%b, want 0/0", if_done, lsb_done);
      end
      n_cmp++;
      if (if_data !== 32'h0 || lsb_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data: if=%h lsb=%h, want 0/0", if_data, lsb_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_if_read();
      int cyc; logic gi, gl; exp_t e;
      if_addr = 32'h1000; if_en = 1'b1;
      exp_q.push_back('{lsb: 1'b0, data: 32'h0000_0013});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_a !== 32'h1000 + k || mem_wr !== 1'b0) begin
            n_err++;
            $display("FAIL if_read_addr edge %0d: mem_a=%h mem_wr=%b, want %h/0", k, mem_a, mem_wr, 32'h1000 + k);
         end
      end
      wait_done(10, cyc, gi, gl);
      if_en = 1'b0;
      n_cmp++;
      if (cyc != 1 || gi !== 1'b1 || gl !== 1'b0) begin
         n_err++;
         $display("FAIL if_read_done: edge %0d if=%b lsb=%b, want edge 5 if=1 lsb=0", cyc + 4, gi, gl);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (if_data !== e.data) begin
         n_err++;
         $display("FAIL if_read_data: got %h, want %h", if_data, e.data);
      end
      idle(3);
      n_cmp++;
      if (if_data !== 32'h0000_0013 || if_done !== 1'b0) begin
         n_err++;
         $display("FAIL if_data_hold: got %h done=%b, want 00000013 done=0", if_data, if_done);
      end
   endtask

   task automatic test_lsb_store();
      int cyc; logic gi, gl; exp_t e;
      logic [31:0] exp_a [3];
      logic [7:0]  exp_d [3];
      logic        exp_w [3];
      exp_a = '{32'h20, 32'h21, 32'h21};
      exp_d = '{8'hCD, 8'hAB, 8'hAB};
      exp_w = '{1'b1, 1'b1, 1'b0};
      lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 3'd2; lsb_addr = 32'h20; lsb_wdata = 32'h0000_ABCD;
      if_en = 1'b1; if_addr = 32'h2000;
      exp_q.push_back('{lsb: 1'b0, data: 32'h4433_2211});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_a !== exp_a[k] || mem_wr !== exp_w[k] || (exp_w[k] && mem_dout !== exp_d[k])) begin
            n_err++;
            $display("FAIL store_beat edge %0d: a=%h d=%h wr=%b, want a=%h d=%h wr=%b",
                     k, mem_a, mem_dout, mem_wr, exp_a[k], exp_d[k], exp_w[k]);
         end
      end
      n_cmp++;
      if (lsb_done !== 1'b1 || if_done !== 1'b0) begin
         n_err++;
         $display("FAIL store_done: lsb=%b if=%b, want 1/0", lsb_done, if_done);
      end
      lsb_en = 1'b0;
      wait_done(20, cyc, gi, gl);
      if_en = 1'b0;
      n_cmp++;
      if (cyc != 6 || gi !== 1'b1) begin
         n_err++;
         $display("FAIL store_then_if_done: edge %0d if=%b, want edge 9 if=1", cyc + 3, gi);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (if_data !== e.data) begin
         n_err++;
         $display("FAIL store_then_if_data: got %h, want %h", if_data, e.data);
      end
      n_cmp++;
      if (ram[16'h20] !== 8'hCD || ram[16'h21] !== 8'hAB) begin
         n_err++;
         $display("FAIL store_ram: got %h %h, want cd ab", ram[16'h20], ram[16'h21]);
      end
      idle(2);
   endtask

   task automatic test_round_robin();
      int cyc; logic gi, gl; exp_t e;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{lsb: 1'b1, data: 32'h0000_0044});
      exp_q.push_back('{lsb: 1'b0, data: 32'h0000_0013});
      exp_q.push_back('{lsb: 1'b1, data: 32'h0000_0044});
      exp_q.push_back('{lsb: 1'b0, data: 32'h0000_0013});
      if_en = 1'b1; if_addr = 32'h1000;
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 3'd1; lsb_addr = 32'h2003;
      for (int t = 0; t < 4; t++) begin
         wait_done(20, cyc, gi, gl);
         e = exp_q.pop_front();
         n_cmp++;
         if (cyc < 0 || gl !== e.lsb || gi !== !e.lsb || (e.lsb ? lsb_rdata : if_data) !== e.data) begin
            n_err++;
            $display("FAIL rr_grant %0d: cyc=%0d if=%b lsb=%b data=%h, want lsb=%b data=%h",
                     t, cyc, gi, gl, e.lsb ? lsb_rdata : if_data, e.lsb, e.data);
         end
      end
      idle(3);
   endtask

   task automatic test_wrap();
      int cyc; logic gi, gl; exp_t e;
      logic [31:0] a;
      a = 32'hFFFF_FFFE;
      if_addr = a; if_en = 1'b1;
      exp_q.push_back('{lsb: 1'b0, data: 32'hD4C3_B2A1});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_a !== a) begin
            n_err++;
            $display("FAIL wrap_addr edge %0d: got %h, want %h", k, mem_a, a);
         end
         a = a + 32'd1;
      end
      wait_done(10, cyc, gi, gl);
      if_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 1 || gi !== 1'b1 || if_data !== e.data) begin
         n_err++;
         $display("FAIL wrap_data: cyc=%0d if=%b data=%h, want cyc=1 if=1 data=%h", cyc, gi, if_data, e.data);
      end
      idle(3);
   endtask

   task automatic test_flush();
      int cyc; logic gi, gl; exp_t e;
      if_addr = 32'h1000; if_en = 1'b1;
      exp_q.push_back('{lsb: 1'b0, data: 32'h4433_2211});
      repeat (3) @(negedge clk);
      flush = 1'b1; if_addr = 32'h2000;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++;
      if (mem_wr !== 1'b0 || if_done !== 1'b0) begin
         n_err++;
         $display("FAIL flush_abort: mem_wr=%b if_done=%b, want 0/0", mem_wr, if_done);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_a !== 32'h2000) begin
         n_err++;
         $display("FAIL flush_reaccept: mem_a=%h, want 00002000", mem_a);
      end
      wait_done(12, cyc, gi, gl);
      if_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 4 || gi !== 1'b1 || if_data !== e.data) begin
         n_err++;
         $display("FAIL flush_if_result: cyc=%0d if=%b data=%h, want cyc=4 if=1 data=%h", cyc, gi, if_data, e.data);
      end
      idle(3);
      lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 3'd4; lsb_addr = 32'h40; lsb_wdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_done(10, cyc, gi, gl);
      lsb_en = 1'b0;
      n_cmp++;
      if (cyc != 1 || gl !== 1'b1) begin
         n_err++;
         $display("FAIL flush_store_done: cyc=%0d lsb=%b, want cyc=1 lsb=1", cyc, gl);
      end
      n_cmp++;
      if ({ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]} !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL flush_store_ram: got %h, want deadbeef",
                  {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]});
      end
      idle(3);
   endtask

   task automatic test_io_stall();
      io_full = 1'b1;
      lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 3'd1; lsb_addr = IO_BASE; lsb_wdata = 32'h0000_005A;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_wr !== 1'b0 || lsb_done !== 1'b0) begin
            n_err++;
            $display("FAIL io_stall edge %0d: mem_wr=%b done=%b, want 0/0", k, mem_wr, lsb_done);
         end
      end
      io_full = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_wr !== 1'b1 || mem_a !== IO_BASE || mem_dout !== 8'h5A) begin
         n_err++;
         $display("FAIL io_issue: wr=%b a=%h d=%h, want 1/%h/5a", mem_wr, mem_a, mem_dout, IO_BASE);
      end
      @(negedge clk);
      lsb_en = 1'b0;
      n_cmp++;
      if (lsb_done !== 1'b1 || mem_wr !== 1'b0) begin
         n_err++;
         $display("FAIL io_done: done=%b wr=%b, want 1/0", lsb_done, mem_wr);
      end
      n_cmp++;
      if (io_q.size() != 1 || io_q[0] !== 8'h5A) begin
         n_err++;
         $display("FAIL io_log: %0d writes first=%h, want 1 write of 5a", io_q.size(),
                  io_q.size() > 0 ? io_q[0] : 8'h00);
      end
      idle(3);
   endtask

   task automatic test_rdy_pause();
      int cyc; logic gi, gl; exp_t e;
      if_addr = 32'h2000; if_en = 1'b1;
      exp_q.push_back('{lsb: 1'b0, data: 32'h4433_2211});
      repeat (3) @(negedge clk);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_a !== 32'h2002 || mem_wr !== 1'b0 || if_done !== 1'b0 || if_data !== 32'h4433_2211) begin
            n_err++;
            $display("FAIL rdy_freeze %0d: a=%h wr=%b done=%b data=%h, want 00002002/0/0/44332211",
                     k, mem_a, mem_wr, if_done, if_data);
         end
      end
      rdy = 1'b1;
      wait_done(10, cyc, gi, gl);
      if_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 2 || gi !== 1'b1 || if_data !== e.data) begin
         n_err++;
         $display("FAIL rdy_resume: cyc=%0d if=%b data=%h, want cyc=2 if=1 data=%h", cyc, gi, if_data, e.data);
      end
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h1000] = 8'h13;
      ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'h33; ram[16'h2003] = 8'h44;
      ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2; ram[16'h0000] = 8'hC3; ram[16'h0001] = 8'hD4;
      test_reset();
      test_if_read();
      test_lsb_store();
      test_round_robin();
      test_wrap();
      test_flush();
      test_io_stall();
      test_rdy_pause();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
